// File: rtl/ldpc_parity_check9_if.sv
// ---------------------------------------------------------------------------
// ldpc_parity_check9_if
// Serial hard-decision bit stream feeding the LDPC parity checker.
//
// Handshake: a bit is transferred on every rising clock edge where
// din_valid and din_ready are both high. The source may raise or drop
// din_valid at any time; while din_valid is high, din must hold the bit being
// offered until it is taken. The sink raises din_ready only in states where it
// can consume a bit, regardless of din_valid.
//
// Signals:
//   din_valid  source -> sink  din carries a codeword bit
//   din        source -> sink  hard-decision codeword bit
//   din_ready  sink -> source  sink accepts a bit this cycle
// ---------------------------------------------------------------------------
interface ldpc_parity_check9_if;
    logic din_valid;
    logic din;
    logic din_ready;

    modport master (
        output din_valid,
        output din,
        input  din_ready
    );

    modport slave (
        input  din_valid,
        input  din,
        output din_ready
    );
endinterface

// File: rtl/ldpc_parity_check9.sv
// ---------------------------------------------------------------------------
// ldpc_parity_check9
// Receive-side parity check for the 360-parallel LDPC code. A codeword arrives
// serially: 4320 information bits (12 groups of 360), then 360 parity bits in
// index order 359 down to 0. The parity accumulator is rebuilt from the
// information bits using the 12-row generator ROM, then compared bit by bit
// with the received parity.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, starts a check (ignored while busy)
//   bus        slave side of the serial bit stream (din_valid/din/din_ready)
//   rom_addr   generator ROM row address (group index)
//   rom_data   ROM row, valid one clock after rom_addr changes
//   busy       high from start acceptance until chk_done
//   chk_done   one-cycle pulse when the check completes
//   chk_pass   all parity bits matched; held until next start
//   err_cnt    number of mismatching parity bits; held until next start
//   dbg_state  current FSM state encoding
// ---------------------------------------------------------------------------
module ldpc_parity_check9 #(
    parameter int Z      = 360,
    parameter int NGRP   = 12,
    parameter int ROM_AW = 4,
    parameter int CW     = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    ldpc_parity_check9_if.slave   bus,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [Z-1:0]          rom_data,
    output logic                  busy,
    output logic                  chk_done,
    output logic                  chk_pass,
    output logic [CW-1:0]         err_cnt,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_INFO   = 3'd3,
        S_PARITY = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CW-1:0]     LAST_POS = CW'(Z - 1);
    localparam logic [ROM_AW-1:0] LAST_GRP = ROM_AW'(NGRP - 1);

    state_t              state;
    logic [Z-1:0]        acc;
    logic [Z-1:0]        row;
    logic [ROM_AW-1:0]   grp;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       idx;

    logic                beat;
    logic                mismatch;
    logic [CW-1:0]       err_next;

    assign beat      = bus.din_valid & bus.din_ready;
    assign mismatch  = bus.din ^ acc[idx];
    assign err_next  = err_cnt + CW'(mismatch);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            row           <= '0;
            grp           <= '0;
            bit_cnt       <= '0;
            idx           <= '0;
            rom_addr      <= '0;
            bus.din_ready <= 1'b0;
            busy          <= 1'b0;
            chk_done      <= 1'b0;
            chk_pass      <= 1'b0;
            err_cnt       <= '0;
        end else begin
            chk_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        err_cnt  <= '0;
                        chk_pass <= 1'b0;
                        grp      <= '0;
                        bit_cnt  <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        state    <= S_FETCH0;
                    end
                end

                // rom_addr already equals grp here; the synchronous ROM
                // registers it at the end of this cycle.
                S_FETCH0: begin
                    state <= S_FETCH1;
                end

                S_FETCH1: begin
                    row           <= rom_data;
                    bus.din_ready <= 1'b1;
                    state         <= S_INFO;
                end

                S_INFO: begin
                    if (beat) begin
                        if (bus.din) begin
                            acc <= acc ^ row;
                        end
                        // Rotate right: bit i of the next position's row is
                        // bit i+1 of this one, matching the encoder.
                        row <= {row[0], row[Z-1:1]};
                        if (bit_cnt == LAST_POS) begin
                            bit_cnt <= '0;
                            if (grp == LAST_GRP) begin
                                idx   <= LAST_POS;
                                state <= S_PARITY;
                            end else begin
                                grp           <= grp + 1'b1;
                                rom_addr      <= grp + 1'b1;
                                bus.din_ready <= 1'b0;
                                state         <= S_FETCH0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (beat) begin
                        err_cnt <= err_next;
                        if (idx == '0) begin
                            chk_done      <= 1'b1;
                            chk_pass      <= (err_next == '0);
                            busy          <= 1'b0;
                            bus.din_ready <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_parity_check9.sv
// ---------------------------------------------------------------------------
// tb_ldpc_parity_check9
// Table of codeword scenarios driven through the checker against a random
// generator ROM; expected {chk_pass, err_cnt} queued at stimulus time and
// popped when chk_done is seen. Hand-written sequences cover reset abort and
// start-while-busy.
// ---------------------------------------------------------------------------
module tb_ldpc_parity_check9;

    localparam int Z      = 360;
    localparam int NGRP   = 12;
    localparam int ROM_AW = 4;
    localparam int CW     = 9;
    localparam int K      = Z * NGRP;
    localparam int N      = K + Z;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic start;
    logic [ROM_AW-1:0] rom_addr;
    logic [Z-1:0]      rom_data;
    logic              busy;
    logic              chk_done;
    logic              chk_pass;
    logic [CW-1:0]     err_cnt;
    logic [2:0]        dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ldpc_parity_check9_if bus ();

    ldpc_parity_check9 #(.Z(Z), .NGRP(NGRP), .ROM_AW(ROM_AW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .chk_done  (chk_done),
        .chk_pass  (chk_pass),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- generator ROM model ----------------
    logic [Z-1:0] rom [NGRP];

    always @(posedge clk) begin
        rom_data <= (int'(rom_addr) < NGRP) ? rom[rom_addr] : '0;
    end

    // ---------------- scoreboard state ----------------
    int total;
    int bad;
    logic [9:0] exp_q[$];

    typedef struct packed {
        logic        pass;
        logic [8:0]  err;
        logic [15:0] beats;
        logic [7:0]  low;
        logic [15:0] lat;
    } done_t;
    done_t done_q[$];

    // Monitor: counts accepted beats and busy-but-not-ready cycles per frame,
    // and records each chk_done with its distance from the last beat.
    int cyc;
    int beats;
    int low;
    int last_cyc;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || (start && !busy)) begin
            beats <= 0;
            low   <= 0;
        end else begin
            if (bus.din_valid && bus.din_ready) begin
                beats    <= beats + 1;
                last_cyc <= cyc;
            end
            if (busy && !bus.din_ready) begin
                low <= low + 1;
            end
        end
        if (rst_n && chk_done) begin
            done_q.push_back({chk_pass, err_cnt, 16'(beats), 8'(low), 16'(cyc - last_cyc)});
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [Z-1:0] rotr1(input logic [Z-1:0] x);
        logic [Z-1:0] r;
        for (int i = 0; i < Z; i++) r[i] = x[(i + 1) % Z];
        return r;
    endfunction

    // Parity bit i collects ROM row g bit (i+pos) for every set info bit.
    function automatic logic [Z-1:0] golden(input logic [K-1:0] info);
        logic [Z-1:0] p;
        p = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int pos = 0; pos < Z; pos++) begin
                if (info[g * Z + pos]) begin
                    for (int i = 0; i < Z; i++) p[i] = p[i] ^ rom[g][(i + pos) % Z];
                end
            end
        end
        return p;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one bit; returns once an edge has taken it (ok=0 on timeout).
    task automatic send_bit(input logic b, input int idle_pct, output logic ok);
        logic taken;
        int guard;
        while ($urandom_range(99, 0) < idle_pct) begin
            bus.din_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.din_valid = 1'b1;
        bus.din       = b;
        guard = 0;
        do begin
            taken = bus.din_ready;
            @(posedge clk); #1;
            guard++;
        end while (!taken && guard < 100);
        ok = taken;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_ready"},     int'(bus.din_ready), 0);
        check({tag, "_done"},      int'(chk_done), 0);
        check({tag, "_pass"},      int'(chk_pass), 0);
        check({tag, "_err"},       int'(err_cnt), 0);
        check({tag, "_rom_addr"},  int'(rom_addr), 0);
    endtask

    // ---------------- vector table ----------------
    // info_mode: 0 zeros, 1 bit0 only, 2 bit1 only, 3 random
    // par_mode : 0 golden, 1 golden with flip_idx flipped, 2 golden inverted,
    //            3 ROM row 0 as-is
    typedef struct {
        int   info_mode;
        int   par_mode;
        int   flip_idx;
        int   idle_pct;
        int   mid_start;
        logic exp_pass;
        int   exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int id, input vec_t v);
        logic [K-1:0] info;
        logic [Z-1:0] par;
        logic [9:0]   exp;
        done_t        got;
        logic         ok;
        logic         b;
        int           g;

        info = '0;
        case (v.info_mode)
            1: info[0] = 1'b1;
            2: info[1] = 1'b1;
            3: for (int k = 0; k < K; k++) info[k] = 1'($urandom_range(1, 0));
            default: info = '0;
        endcase
        par = golden(info);
        case (v.par_mode)
            1: par[v.flip_idx] = ~par[v.flip_idx];
            2: par = ~par;
            3: par = rom[0];
            default: ;
        endcase

        exp_q.push_back({v.exp_pass, 9'(v.exp_err)});
        pulse_start();
        for (int k = 0; k < N; k++) begin
            b = (k < K) ? info[k] : par[Z - 1 - (k - K)];
            if (k == v.mid_start) start = 1'b1;
            send_bit(b, v.idle_pct, ok);
            start = 1'b0;
            if (!ok) begin
                check($sformatf("v%0d_accept_timeout_bit%0d", id, k), 0, 1);
                break;
            end
        end
        bus.din_valid = 1'b0;

        g = 0;
        while (done_q.size() == 0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        exp = exp_q.pop_front();
        if (done_q.size() == 0) begin
            check($sformatf("v%0d_done_timeout", id), 0, 1);
        end else begin
            got = done_q.pop_front();
            check($sformatf("v%0d_pass", id),  int'(got.pass),  int'(exp[9]));
            check($sformatf("v%0d_err", id),   int'(got.err),   int'(exp[8:0]));
            check($sformatf("v%0d_beats", id), int'(got.beats), N);
            check($sformatf("v%0d_fetch_low", id), int'(got.low), 2 * NGRP);
            check($sformatf("v%0d_latency", id), int'(got.lat), 1);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_held_err", id),  int'(err_cnt),  int'(exp[8:0]));
            check($sformatf("v%0d_held_pass", id), int'(chk_pass), int'(exp[9]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic ok;
        int hd;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;

        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < Z; i++) rom[g][i] = 1'($urandom_range(1, 0));
        end
        hd = $countones(rom[0] ^ rotr1(rom[0]));

        vecs[0] = '{0, 0, 0,  0,   -1, 1'b1, 0};
        vecs[1] = '{1, 0, 0,  0,   -1, 1'b1, 0};
        vecs[2] = '{1, 1, 17, 0,   -1, 1'b0, 1};
        vecs[3] = '{2, 3, 0,  0,   -1, (hd == 0), hd};
        vecs[4] = '{3, 0, 0,  30,  -1, 1'b1, 0};
        vecs[5] = '{3, 2, 0,  30,  -1, 1'b0, 360};
        vecs[6] = '{3, 0, 0,  0,   -1, 1'b1, 0};
        vecs[7] = '{3, 0, 0,  10, 1000, 1'b1, 0};
        vecs[8] = '{3, 0, 0,  0,   -1, 1'b1, 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Abort mid-INFO in group 5: outputs return to reset values at once
        // and the frame never reports completion.
        pulse_start();
        for (int k = 0; k < 5 * Z + 100; k++) begin
            send_bit(1'($urandom_range(1, 0)), 0, ok);
            if (!ok) begin
                check("abort_accept_timeout", 0, 1);
                break;
            end
        end
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_q.size(), 0);
        check("abort_idle_busy", int'(busy), 0);

        for (int i = 7; i < 9; i++) run_vec(i, vecs[i]);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
